polar_to_cartesian: RTL and testbench

POLAR_TO_CARTESIAN -- requirements
Module: polar_to_cartesian

---
 rtl/polar_to_cartesian.sv | 116 +++++++++++
 tb/tb_polar_to_cartesian.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/polar_to_cartesian.sv
// Pipelined CORDIC rotator: converts a (magnitude, phase) sample into (I, Q) with
// a quadrant pre-rotation stage followed by DEPTH shift-and-add rotation stages.
module polar_to_cartesian #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [2*WIDTH-1:0] s_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [2*WIDTH-1:0] m_data
);

  localparam int  XW = WIDTH + 2;
  localparam real PI = 3.14159265358979323846;
  localparam logic [WIDTH-1:0] QUARTER = {2'b01, {(WIDTH-2){1'b0}}};

  // atan(2^-k) in phase units (2^(WIDTH-1) == pi), truncated toward zero
  function automatic int atanLut(input int k);
    real a;
    a = $atan(1.0 / (2.0 ** k)) * (2.0 ** (WIDTH - 1)) / PI;
    return $rtoi(a);
  endfunction

  logic signed [WIDTH-1:0] lut [DEPTH];
  for (genvar k = 0; k < DEPTH; k++) begin : g_lut
    localparam logic signed [WIDTH-1:0] ANG = WIDTH'(atanLut(k));
    assign lut[k] = ANG;
  end

  logic             adv;
  logic             accept;
  logic [DEPTH-1:0] vld_q, vld_d;
  logic             m_valid_q, m_valid_d;

  logic signed [XW-1:0]    x_q [DEPTH+1];
  logic signed [XW-1:0]    y_q [DEPTH+1];
  logic signed [WIDTH-1:0] z_q [DEPTH+1];
  logic signed [XW-1:0]    x_d [DEPTH+1];
  logic signed [XW-1:0]    y_d [DEPTH+1];
  logic signed [WIDTH-1:0] z_d [DEPTH+1];

  logic signed [XW-1:0]    magExt;
  logic        [WIDTH-1:0] phase;

  assign adv     = !m_valid_q || m_ready;
  assign s_ready = adv && !reset;
  assign accept  = s_valid && s_ready;

  assign magExt = {{2{s_data[2*WIDTH-1]}}, s_data[2*WIDTH-1:WIDTH]};
  assign phase  = s_data[WIDTH-1:0];

  always_comb begin
    vld_d     = adv ? ((vld_q << 1) | DEPTH'(accept)) : vld_q;
    m_valid_d = adv ? vld_q[DEPTH-1] : m_valid_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q     <= '0;
      m_valid_q <= 1'b0;
    end else begin
      vld_q     <= vld_d;
      m_valid_q <= m_valid_d;
    end
  end

  // Stage 0 folds the phase into [-pi/2, pi/2] so the rotation stages converge
  always_comb begin
    x_d[0] = '0;
    y_d[0] = '0;
    z_d[0] = phase;
    case (phase[WIDTH-1:WIDTH-2])
      2'b01: begin
        y_d[0] = magExt;
        z_d[0] = phase - QUARTER;
      end
      2'b10: begin
        y_d[0] = -magExt;
        z_d[0] = phase + QUARTER;
      end
      default: x_d[0] = magExt;
    endcase
    for (int n = 1; n <= DEPTH; n++) begin
      if (z_q[n-1][WIDTH-1]) begin
        x_d[n] = x_q[n-1] + (y_q[n-1] >>> (n - 1));
        y_d[n] = y_q[n-1] - (x_q[n-1] >>> (n - 1));
        z_d[n] = z_q[n-1] + lut[n-1];
      end else begin
        x_d[n] = x_q[n-1] - (y_q[n-1] >>> (n - 1));
        y_d[n] = y_q[n-1] + (x_q[n-1] >>> (n - 1));
        z_d[n] = z_q[n-1] - lut[n-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      x_q <= x_d;
      y_q <= y_d;
      z_q <= z_d;
    end
  end

  // Dropping bit 0 halves the CORDIC gain so full-scale inputs fit WIDTH bits
  assign m_valid = m_valid_q;
  assign m_data  = {y_q[DEPTH][WIDTH:1], x_q[DEPTH][WIDTH:1]};

  logic unused_bits;
  assign unused_bits = ^{x_q[DEPTH][XW-1], x_q[DEPTH][0],
                         y_q[DEPTH][XW-1], y_q[DEPTH][0], z_q[DEPTH]};

endmodule

// File: tb/tb_polar_to_cartesian.sv
// Testbench for polar_to_cartesian (WIDTH=16, DEPTH=16): directed vectors with
// tolerance, randomized streams against an arithmetic CORDIC model, stalls and resets.
module tb_polar_to_cartesian;

  localparam int  W  = 16;
  localparam int  D  = 16;
  localparam real PI = 3.14159265358979323846;

  logic           clk = 1'b0;
  logic           reset;
  logic           s_valid;
  logic           s_ready;
  logic [2*W-1:0] s_data;
  logic           m_valid;
  logic           m_ready;
  logic [2*W-1:0] m_data;

  polar_to_cartesian #(.WIDTH(W), .DEPTH(D)) dut (
    .clk    (clk),
    .reset  (reset),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_data (s_data),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data (m_data)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle++;

  int errors = 0;
  int checks = 0;
  int lut [D];

  logic [31:0] expQ [$];
  logic [31:0] obsQ [$];
  int          accCyc [$];
  int          obsCyc [$];

  // Ideal CORDIC from the algorithm's rules, using unbounded integer arithmetic
  function automatic logic [31:0] model(input logic [31:0] d);
    longint x, y, z, mag, nx;
    logic [15:0] iOut, qOut;
    mag = longint'($signed(d[31:16]));
    z   = longint'($signed(d[15:0]));
    x   = mag;
    y   = 0;
    if (d[15:14] == 2'b01) begin
      x = 0; y = mag; z = z - 16384;
    end else if (d[15:14] == 2'b10) begin
      x = 0; y = -mag; z = z + 16384;
    end
    for (int s = 0; s < D; s++) begin
      if (z < 0) begin
        nx = x + (y >>> s); y = y - (x >>> s); x = nx; z = z + lut[s];
      end else begin
        nx = x - (y >>> s); y = y + (x >>> s); x = nx; z = z - lut[s];
      end
    end
    iOut = 16'(x >>> 1);
    qOut = 16'(y >>> 1);
    return {qOut, iOut};
  endfunction

  // Records every handshake that will complete on the coming rising edge
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (s_valid && s_ready) begin
        expQ.push_back(model(s_data));
        accCyc.push_back(cycle + 1);
      end
      if (m_valid && m_ready) begin
        obsQ.push_back(m_data);
        obsCyc.push_back(cycle);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_queues();
    expQ.delete();
    obsQ.delete();
    accCyc.delete();
    obsCyc.delete();
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    s_valid = 1'b0;
    s_data  = '0;
    m_ready = 1'b1;
    tick();
    tick();
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_m_valid got=%b want=0", m_valid);
    end
    checks++;
    if (s_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_s_ready got=%b want=0", s_ready);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if (s_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL release_s_ready got=%b want=1", s_ready);
    end
    checks++;
    if (m_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL release_m_valid got=%b want=0", m_valid);
    end
    tick();
  endtask

  task automatic send_one(input string name, input int mag, input int ph,
                          input int expI, input int expQv);
    bit found;
    int gotI, gotQ, lat;
    clear_queues();
    m_ready = 1'b1;
    s_valid = 1'b1;
    s_data  = {16'(mag), 16'(ph)};
    @(negedge clk);
    checks++;
    if (s_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL %s_s_ready got=%b want=1", name, s_ready);
    end
    tick();
    s_valid = 1'b0;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (m_valid === 1'b1) found = 1;
    end
    checks++;
    if (!found || accCyc.size() == 0) begin
      errors++; $display("[TB] FAIL %s_timeout got=no_output want=output", name);
    end else begin
      lat  = cycle - accCyc[0];
      gotI = int'($signed(m_data[15:0]));
      gotQ = int'($signed(m_data[31:16]));
      checks++;
      if (lat !== D) begin
        errors++; $display("[TB] FAIL %s_latency got=%0d want=%0d", name, lat, D);
      end
      checks++;
      if (gotI > expI + 3 || gotI < expI - 3) begin
        errors++; $display("[TB] FAIL %s_I got=%0d want=%0d+/-3", name, gotI, expI);
      end
      checks++;
      if (gotQ > expQv + 3 || gotQ < expQv - 3) begin
        errors++; $display("[TB] FAIL %s_Q got=%0d want=%0d+/-3", name, gotQ, expQv);
      end
      checks++;
      if (m_data !== expQ[0]) begin
        errors++; $display("[TB] FAIL %s_exact got=%h want=%h", name, m_data, expQ[0]);
      end
    end
    tick();
  endtask

  task automatic test_directed();
    send_one("ph0",      10000,      0,   8234,      0);
    send_one("ph90",     10000,  16384,      0,   8234);
    send_one("phm90",    10000, -16384,      0,  -8234);
    send_one("ph180",    10000, -32768,  -8234,      0);
    send_one("ph45",     10000,   8192,   5822,   5822);
    send_one("ph135max", 32767,  24576, -19080,  19080);
    send_one("negmag",  -10000,      0,  -8234,      0);
  endtask

  task automatic run_stream(input string name, input int n, input int validPct,
                            input int readyPct, input int stallAt, input int stallLen);
    int sent;
    bit prevStall;
    logic [31:0] prevData;
    clear_queues();
    sent      = 0;
    prevStall = 0;
    prevData  = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc >= stallAt && cyc < stallAt + stallLen) m_ready = 1'b0;
      else m_ready = ($urandom_range(99) < readyPct);
      s_valid = (sent < n) && ($urandom_range(99) < validPct);
      s_data  = $urandom;
      @(negedge clk);
      if (prevStall) begin
        checks++;
        if (m_valid !== 1'b1 || m_data !== prevData) begin
          errors++;
          $display("[TB] FAIL %s_stall_hold got=%b/%h want=1/%h", name, m_valid, m_data, prevData);
        end
      end
      prevStall = m_valid && !m_ready;
      prevData  = m_data;
      if (s_valid && s_ready) sent++;
      @(posedge clk);
      #1;
      if (sent == n && obsQ.size() >= n) break;
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    checks++;
    if (obsQ.size() != n) begin
      errors++; $display("[TB] FAIL %s_count got=%0d want=%0d", name, obsQ.size(), n);
    end
    for (int i = 0; i < n && i < obsQ.size() && i < expQ.size(); i++) begin
      checks++;
      if (obsQ[i] !== expQ[i]) begin
        errors++; $display("[TB] FAIL %s_data[%0d] got=%h want=%h", name, i, obsQ[i], expQ[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    run_stream("b2b", 40, 100, 100, 22, 5);
  endtask

  task automatic test_random_flow();
    run_stream("rand", 60, 70, 60, 0, 0);
  endtask

  task automatic test_bubble();
    logic [6:0] pattern;
    pattern = 7'b1001101;
    clear_queues();
    m_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      s_valid = pattern[i];
      s_data  = $urandom;
      tick();
    end
    s_valid = 1'b0;
    for (int i = 0; i < 25; i++) tick();
    checks++;
    if (obsQ.size() != 4) begin
      errors++; $display("[TB] FAIL bubble_count got=%0d want=4", obsQ.size());
    end
    for (int i = 0; i < obsQ.size() && i < accCyc.size(); i++) begin
      checks++;
      if (obsCyc[i] - accCyc[i] != D || obsQ[i] !== expQ[i]) begin
        errors++;
        $display("[TB] FAIL bubble_out[%0d] got=lat%0d/%h want=lat%0d/%h",
                 i, obsCyc[i] - accCyc[i], obsQ[i], D, expQ[i]);
      end
    end
  endtask

  task automatic test_reset_midstream();
    clear_queues();
    m_ready = 1'b1;
    for (int i = 0; i < 24; i++) begin
      s_valid = 1'b1;
      s_data  = $urandom;
      tick();
    end
    s_valid = 1'b0;
    reset   = 1'b1;
    @(negedge clk);
    checks++;
    if (s_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL midreset_s_ready got=%b want=0", s_ready);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_release got=%b/%b want=1/0", s_ready, m_valid);
    end
    clear_queues();
    for (int i = 0; i < 30; i++) tick();
    checks++;
    if (obsQ.size() != 0) begin
      errors++; $display("[TB] FAIL midreset_ghost got=%0d want=0", obsQ.size());
    end
    send_one("after_reset", 10000, 0, 8234, 0);
  endtask

  initial begin
    for (int k = 0; k < D; k++) lut[k] = $rtoi($atan(1.0 / (2.0 ** k)) * 32768.0 / PI);
    test_reset();
    test_directed();
    test_back_to_back();
    test_bubble();
    test_random_flow();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
